can_tx_scheduler: RTL and testbench

Transmit scheduler for the CAN controller's message buffers. It watches the transmit-request bits of NBUF transmit message control registers and picks the pending buffer with the highest-priority identifier. It then hands that buffer to the LLC/MAC transmit path, follows the frame to its outcome, and drives each control register's `can` write strobe so that treq is cleared and the transmit indication is set. Position: between the register file (transmit control registers, identifier registers) and the LLC.

---
 rtl/can_tx_pkg.sv | 23 ++
 rtl/can_tx_prio_sel.sv | 32 +++
 rtl/can_tx_scheduler.sv | 150 +++++++++++++++
 tb/tb_can_tx_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_tx_pkg.sv
// Shared types and constants for the CAN transmit scheduler.
package can_tx_pkg;

   localparam int NBUF_DEF = 4;
   localparam int IDW_DEF  = 11;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      START,
      WAIT_TX,
      COMPLETE
   } tx_state_t;

   // Retry counter width: enough to hold retry_max, never narrower than one bit
   function automatic int retry_cnt_w(input int retry_max);
      if (retry_max < 1) begin
         return 1;
      end
      return $clog2(retry_max + 1);
   endfunction

endpackage

// File: rtl/can_tx_prio_sel.sv
// Combinational finder for the requesting buffer with the lowest identifier.
// Equal identifiers resolve to the lowest buffer index.
module can_tx_prio_sel
   import can_tx_pkg::*;
#(
   parameter int NBUF = NBUF_DEF,
   parameter int IDW  = IDW_DEF,
   localparam int SW  = $clog2(NBUF)
) (
   input  logic [NBUF-1:0]     req,
   input  logic [NBUF*IDW-1:0] id_flat,
   output logic                valid,
   output logic [SW-1:0]       idx
);

   logic [IDW-1:0] best_id;

   // Linear scan; a strict less-than keeps the earlier index on ties
   always_comb begin
      valid   = 1'b0;
      idx     = '0;
      best_id = '0;
      for (int i = 0; i < NBUF; i++) begin
         if (req[i] && (!valid || (id_flat[i*IDW +: IDW] < best_id))) begin
            valid   = 1'b1;
            idx     = SW'(i);
            best_id = id_flat[i*IDW +: IDW];
         end
      end
   end

endmodule

// File: rtl/can_tx_scheduler.sv
// Transmit scheduler: picks the highest-priority pending buffer, hands it to
// the LLC, follows the frame to its outcome and strobes the buffer's control
// register when the frame is finished (sent, or retry budget exhausted).
module can_tx_scheduler
   import can_tx_pkg::*;
#(
   parameter int NBUF      = NBUF_DEF,
   parameter int IDW       = IDW_DEF,
   parameter int RETRY_MAX = 0,
   localparam int SW       = $clog2(NBUF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NBUF-1:0]     treq,
   input  logic [NBUF*IDW-1:0] prio_id,
   input  logic                busidle,
   input  logic                llc_tsucf,
   input  logic                llc_arblost,
   input  logic                llc_txerr,
   output logic                tx_start,
   output logic [SW-1:0]       tx_sel,
   output logic [NBUF-1:0]     done_can,
   output logic                done_ok,
   output logic                busy
);

   localparam int CW = retry_cnt_w(RETRY_MAX);

   tx_state_t       state, state_nx;
   logic            req_seen, req_seen_nx;
   logic            ok, ok_nx;
   logic [CW-1:0]   retry_cnt, retry_cnt_nx;
   logic [SW-1:0]   retry_buf, retry_buf_nx;
   logic [SW-1:0]   tx_sel_nx;
   logic            tx_start_nx;
   logic [NBUF-1:0] done_can_nx;
   logic            done_ok_nx;
   logic            win_valid;
   logic [SW-1:0]   win_idx;
   logic            retry_limit_hit;

   can_tx_prio_sel #(
      .NBUF (NBUF),
      .IDW  (IDW)
   ) u_prio_sel (
      .req     (treq),
      .id_flat (prio_id),
      .valid   (win_valid),
      .idx     (win_idx)
   );

   // The error being counted now is the last one allowed when a limit is set
   always_comb begin
      retry_limit_hit = (RETRY_MAX != 0) && ((int'(retry_cnt) + 1) >= RETRY_MAX);
   end

   // Next-state and next-output decisions; IDLE only leaves on a request seen
   // in IDLE the cycle before, so treq cleared by our own strobe is never reused
   always_comb begin
      state_nx     = state;
      req_seen_nx  = (state == IDLE) && (|treq) && busidle;
      ok_nx        = ok;
      retry_cnt_nx = retry_cnt;
      retry_buf_nx = retry_buf;
      tx_sel_nx    = tx_sel;
      tx_start_nx  = 1'b0;
      done_can_nx  = '0;
      done_ok_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (req_seen) begin
               state_nx = SELECT;
            end
         end
         SELECT: begin
            if (win_valid) begin
               tx_sel_nx = win_idx;
               state_nx  = START;
               if (win_idx != retry_buf) begin
                  retry_cnt_nx = '0;
                  retry_buf_nx = win_idx;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         START: begin
            if (treq[tx_sel]) begin
               tx_start_nx = 1'b1;
               state_nx    = WAIT_TX;
            end else begin
               state_nx = IDLE;
            end
         end
         WAIT_TX: begin
            if (llc_tsucf) begin
               ok_nx    = 1'b1;
               state_nx = COMPLETE;
            end else if (llc_txerr) begin
               retry_cnt_nx = (&retry_cnt) ? retry_cnt : retry_cnt + 1'b1;
               if (retry_limit_hit) begin
                  ok_nx    = 1'b0;
                  state_nx = COMPLETE;
               end else begin
                  state_nx = IDLE;
               end
            end else if (llc_arblost) begin
               state_nx = IDLE;
            end
         end
         COMPLETE: begin
            done_can_nx  = NBUF'(1) << tx_sel;
            done_ok_nx   = ok;
            retry_cnt_nx = '0;
            state_nx     = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State, retry bookkeeping and all outputs are registered here
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         req_seen  <= 1'b0;
         ok        <= 1'b0;
         retry_cnt <= '0;
         retry_buf <= '0;
         tx_sel    <= '0;
         tx_start  <= 1'b0;
         done_can  <= '0;
         done_ok   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         req_seen  <= req_seen_nx;
         ok        <= ok_nx;
         retry_cnt <= retry_cnt_nx;
         retry_buf <= retry_buf_nx;
         tx_sel    <= tx_sel_nx;
         tx_start  <= tx_start_nx;
         done_can  <= done_can_nx;
         done_ok   <= done_ok_nx;
         busy      <= (state != IDLE);
      end
   end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: two instances (retry limit 3 and unlimited)
// share stimulus; each has its own emulated treq register bits, cleared when
// that instance strobes done_can. A transaction-level model predicts outputs.
module tb_can_tx_scheduler;

   localparam int P_IDLE   = 0;
   localparam int P_ARB    = 1;
   localparam int P_CHECK  = 2;
   localparam int P_BUS    = 3;
   localparam int P_REPORT = 4;

   typedef struct packed {
      int         phase;
      int         sel;
      int         errOwner;
      int         errCount;
      logic       okm;
      logic       seen;
      logic       start;
      logic [3:0] can;
      logic       ok;
      logic       busy;
   } mdl_t;

   logic        clk;
   logic        rst;
   logic [3:0]  treq3, treq0;
   logic [10:0] ids [4];
   logic [43:0] prio_id;
   logic        busidle, llc_tsucf, llc_arblost, llc_txerr;
   logic        ts3, ok3, busy3, ts0, ok0, busy0;
   logic [1:0]  sel3, sel0;
   logic [3:0]  dc3, dc0;

   int   passCount, totalCount;
   int   starts3, starts0, dones3, dones0;
   logic [3:0] lastDone3, lastDone0;
   logic lastOk3, lastOk0;
   mdl_t m3, m0;

   assign prio_id = {ids[3], ids[2], ids[1], ids[0]};

   can_tx_scheduler #(.NBUF(4), .IDW(11), .RETRY_MAX(3)) u_dut3 (
      .clk(clk), .rst(rst), .treq(treq3), .prio_id(prio_id), .busidle(busidle),
      .llc_tsucf(llc_tsucf), .llc_arblost(llc_arblost), .llc_txerr(llc_txerr),
      .tx_start(ts3), .tx_sel(sel3), .done_can(dc3), .done_ok(ok3), .busy(busy3)
   );

   can_tx_scheduler #(.NBUF(4), .IDW(11), .RETRY_MAX(0)) u_dut0 (
      .clk(clk), .rst(rst), .treq(treq0), .prio_id(prio_id), .busidle(busidle),
      .llc_tsucf(llc_tsucf), .llc_arblost(llc_arblost), .llc_txerr(llc_txerr),
      .tx_start(ts0), .tx_sel(sel0), .done_can(dc0), .done_ok(ok0), .busy(busy0)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, report a mismatch
   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Requesting buffer with the smallest identifier, earliest index on ties
   function automatic int pickWinner(input logic [3:0] tq);
      int best;
      best = -1;
      for (int i = 0; i < 4; i++) begin
         if (tq[i] && ((best < 0) || (ids[i] < ids[best]))) begin
            best = i;
         end
      end
      return best;
   endfunction

   // Advance the frame-lifecycle model by one clock edge
   function automatic mdl_t modelStep(input mdl_t m, input logic [3:0] tq, input int rmax);
      mdl_t n;
      int   w;
      n = m;
      if (!rst) begin
         n = '0;
         return n;
      end
      n.start = 1'b0;
      n.can   = 4'b0000;
      n.ok    = 1'b0;
      n.busy  = (m.phase != P_IDLE);
      n.seen  = (m.phase == P_IDLE) && (tq != 4'b0000) && busidle;
      case (m.phase)
         P_IDLE: if (m.seen) n.phase = P_ARB;
         P_ARB: begin
            w = pickWinner(tq);
            if (w < 0) begin
               n.phase = P_IDLE;
            end else begin
               if (w != m.errOwner) begin
                  n.errCount = 0;
                  n.errOwner = w;
               end
               n.sel   = w;
               n.phase = P_CHECK;
            end
         end
         P_CHECK: begin
            if (tq[m.sel]) begin
               n.start = 1'b1;
               n.phase = P_BUS;
            end else begin
               n.phase = P_IDLE;
            end
         end
         P_BUS: begin
            if (llc_tsucf) begin
               n.okm   = 1'b1;
               n.phase = P_REPORT;
            end else if (llc_txerr) begin
               n.errCount = m.errCount + 1;
               if ((rmax != 0) && (n.errCount >= rmax)) begin
                  n.okm   = 1'b0;
                  n.phase = P_REPORT;
               end else begin
                  n.phase = P_IDLE;
               end
            end else if (llc_arblost) begin
               n.phase = P_IDLE;
            end
         end
         default: begin
            n.can      = 4'b0001 << m.sel;
            n.ok       = m.okm;
            n.errCount = 0;
            n.phase    = P_IDLE;
         end
      endcase
      return n;
   endfunction

   // Compare one instance's outputs with its model
   task automatic compareDut(input string pfx, input logic st, input logic [1:0] sl,
                             input logic [3:0] dc, input logic dok, input logic bsy, input mdl_t m);
      checkOutput({pfx, ".tx_start"}, st, m.start);
      checkOutput({pfx, ".tx_sel"}, sl, m.sel);
      checkOutput({pfx, ".done_can"}, dc, m.can);
      checkOutput({pfx, ".busy"}, bsy, m.busy);
      if (m.can != 4'b0000) begin
         checkOutput({pfx, ".done_ok"}, dok, m.ok);
      end
   endtask

   // One clock: model + compare after the edge, register-file emulation at negedge
   task automatic tick();
      @(posedge clk);
      m3 = modelStep(m3, treq3, 3);
      m0 = modelStep(m0, treq0, 0);
      #1;
      compareDut("r3", ts3, sel3, dc3, ok3, busy3, m3);
      compareDut("r0", ts0, sel0, dc0, ok0, busy0, m0);
      @(negedge clk);
      if (ts3) starts3++;
      if (ts0) starts0++;
      if (dc3 != 4'b0000) begin
         dones3++;
         lastDone3 = dc3;
         lastOk3   = ok3;
         treq3     = treq3 & ~dc3;
      end
      if (dc0 != 4'b0000) begin
         dones0++;
         lastDone0 = dc0;
         lastOk0   = ok0;
         treq0     = treq0 & ~dc0;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Raise the transmit request of buffer b in both register files
   task automatic applyStimulus(input int b, input logic [10:0] id);
      ids[b]   = id;
      treq3[b] = 1'b1;
      treq0[b] = 1'b1;
   endtask

   task automatic clearReq(input int b);
      treq3[b] = 1'b0;
      treq0[b] = 1'b0;
   endtask

   // One-cycle LLC pulse(s)
   task automatic pulse(input logic s, input logic a, input logic e);
      llc_tsucf   = s;
      llc_arblost = a;
      llc_txerr   = e;
      tick();
      llc_tsucf   = 1'b0;
      llc_arblost = 1'b0;
      llc_txerr   = 1'b0;
   endtask

   // Wait (bounded) for tx_start of one instance; lat counts clocks waited
   task automatic waitStart(input bit useZero, output int sel, output int lat);
      logic found;
      found = 1'b0;
      sel   = -1;
      lat   = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         lat++;
         if (useZero ? ts0 : ts3) begin
            found = 1'b1;
            sel   = useZero ? int'(sel0) : int'(sel3);
         end
      end
      checkOutput("start_seen", found, 1'b1);
   endtask

   // Directed scenarios
   initial begin
      int sel, lat, s3, s0, d0, d3;
      int expOrder [3];
      passCount = 0; totalCount = 0;
      starts3 = 0; starts0 = 0; dones3 = 0; dones0 = 0;
      lastDone3 = '0; lastDone0 = '0; lastOk3 = 1'b0; lastOk0 = 1'b0;
      m3 = '0; m0 = '0;
      treq3 = '0; treq0 = '0;
      for (int i = 0; i < 4; i++) ids[i] = '0;
      rst = 1'b0; busidle = 1'b1;
      llc_tsucf = 1'b0; llc_arblost = 1'b0; llc_txerr = 1'b0;

      ticks(3);
      checkOutput("reset_tx_start", ts3, 1'b0);
      checkOutput("reset_busy", busy3, 1'b0);
      checkOutput("reset_done_can", dc3, 4'b0000);
      rst = 1'b1;
      ticks(2);

      $display("[TB] single request");
      applyStimulus(0, 11'h123);
      waitStart(1'b0, sel, lat);
      checkOutput("single_latency", lat, 4);
      checkOutput("single_sel", sel, 0);
      pulse(1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("single_done_can", dc3, 4'b0001);
      checkOutput("single_done_ok", ok3, 1'b1);
      checkOutput("single_busy_during_done", busy3, 1'b1);
      tick();
      checkOutput("single_busy_drop", busy3, 1'b0);
      ticks(2);

      $display("[TB] priority");
      expOrder[0] = 1; expOrder[1] = 3; expOrder[2] = 0;
      applyStimulus(0, 11'h200);
      applyStimulus(1, 11'h050);
      applyStimulus(3, 11'h050);
      for (int k = 0; k < 3; k++) begin
         waitStart(1'b0, sel, lat);
         checkOutput($sformatf("prio_order_%0d", k), sel, expOrder[k]);
         pulse(1'b1, 1'b0, 1'b0);
         ticks(2);
      end

      $display("[TB] stray llc pulse while idle");
      d3 = dones3;
      pulse(1'b1, 1'b0, 1'b0);
      ticks(3);
      checkOutput("idle_pulse_ignored", dones3, d3);

      $display("[TB] arbitration loss");
      d3 = dones3;
      applyStimulus(0, 11'h300);
      waitStart(1'b0, sel, lat);
      checkOutput("arb_first_sel", sel, 0);
      applyStimulus(1, 11'h010);
      pulse(1'b0, 1'b1, 1'b0);
      waitStart(1'b0, sel, lat);
      checkOutput("arb_resel", sel, 1);
      checkOutput("arb_no_done", dones3, d3);
      pulse(1'b1, 1'b0, 1'b0);
      ticks(2);
      waitStart(1'b0, sel, lat);
      checkOutput("arb_then_buf0", sel, 0);
      pulse(1'b1, 1'b0, 1'b0);
      ticks(2);

      $display("[TB] simultaneous success and error");
      applyStimulus(3, 11'h100);
      waitStart(1'b0, sel, lat);
      pulse(1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("simul_done_can", dc3, 4'b1000);
      checkOutput("simul_done_ok", ok3, 1'b1);
      ticks(2);

      $display("[TB] retry limit");
      s3 = starts3; s0 = starts0; d0 = dones0;
      applyStimulus(2, 11'h0AA);
      for (int e = 0; e < 20; e++) begin
         waitStart(1'b1, sel, lat);
         if (e == 0) checkOutput("retry_sel", sel, 2);
         pulse(1'b0, 1'b0, 1'b1);
      end
      checkOutput("retry3_starts", starts3 - s3, 3);
      checkOutput("retry3_done_can", lastDone3, 4'b0100);
      checkOutput("retry3_done_ok", lastOk3, 1'b0);
      checkOutput("retry0_no_done", dones0 - d0, 0);
      waitStart(1'b1, sel, lat);
      checkOutput("retry0_starts", starts0 - s0, 21);
      pulse(1'b1, 1'b0, 1'b0);
      ticks(2);
      checkOutput("retry0_final_done", dones0 - d0, 1);
      checkOutput("retry0_final_can", lastDone0, 4'b0100);

      $display("[TB] abort during select and start");
      s3 = starts3;
      applyStimulus(1, 11'h111);
      ticks(2);
      clearReq(1);
      ticks(6);
      checkOutput("abort_select_no_start", starts3 - s3, 0);
      applyStimulus(1, 11'h111);
      ticks(3);
      clearReq(1);
      ticks(6);
      checkOutput("abort_start_no_start", starts3 - s3, 0);
      checkOutput("abort_busy", busy3, 1'b0);

      $display("[TB] busidle gating and reset mid-frame");
      busidle = 1'b0;
      applyStimulus(3, 11'h123);
      ticks(5);
      checkOutput("busidle_hold", starts3 - s3, 0);
      busidle = 1'b1;
      waitStart(1'b0, sel, lat);
      checkOutput("reset_pre_sel", sel, 3);
      rst = 1'b0;
      tick();
      checkOutput("rst_tx_start", ts3, 1'b0);
      checkOutput("rst_tx_sel", sel3, 2'd0);
      checkOutput("rst_done_can", dc3, 4'b0000);
      checkOutput("rst_done_ok", ok3, 1'b0);
      checkOutput("rst_busy", busy3, 1'b0);
      clearReq(3);
      rst = 1'b1;
      ticks(4);

      $display("[TB] %0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
